// File: rtl/mul9x9_ireg_checker_if.sv
// Stimulus/observation bundle between a test harness and the 9x9 multiplier checker.
// The master drives stimulus and the multiplier's Z; the slave reports results.
interface mul9x9_ireg_checker_if #(
    parameter int CNT_W = 16
);
    logic             clr;
    logic             strobe;
    logic             cea, ceb;
    logic             rsta, rstb;
    logic             a_signed, b_signed;
    logic [8:0]       a, b;
    logic [17:0]      z;
    logic             err;
    logic [CNT_W-1:0] check_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [17:0]      first_z, first_exp;

    modport master (
        output clr, strobe, cea, ceb, rsta, rstb, a_signed, b_signed, a, b, z,
        input  err, check_cnt, err_cnt, first_z, first_exp
    );
    modport slave (
        input  clr, strobe, cea, ceb, rsta, rstb, a_signed, b_signed, a, b, z,
        output err, check_cnt, err_cnt, first_z, first_exp
    );
endinterface

// File: rtl/mul9x9_ireg_checker.sv
// Checks a 9x9 multiplier with registered A/B and combinational Z against a
// cycle-accurate model of its input registers; sticky error, counters, first-miss snapshot.
module mul9x9_ireg_checker #(
    parameter int CNT_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    mul9x9_ireg_checker_if.slave   bus
);
    logic [8:0]  ra, rb;
    logic        va, vb;
    logic [17:0] ax, bx, exp_z;
    logic        cmp, miss;

    // Signedness follows the live inputs, not the value at load time.
    assign ax    = bus.a_signed ? {{9{ra[8]}}, ra} : {9'b0, ra};
    assign bx    = bus.b_signed ? {{9{rb[8]}}, rb} : {9'b0, rb};
    assign exp_z = ax * bx;
    assign cmp   = va && vb;
    assign miss  = bus.z != exp_z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra <= '0;
            rb <= '0;
            va <= 1'b0;
            vb <= 1'b0;
        end else begin
            if (bus.strobe && bus.rsta) begin
                ra <= '0;
                va <= 1'b1;
            end else if (bus.strobe && bus.cea) begin
                ra <= bus.a;
                va <= 1'b1;
            end
            if (bus.strobe && bus.rstb) begin
                rb <= '0;
                vb <= 1'b1;
            end else if (bus.strobe && bus.ceb) begin
                rb <= bus.b;
                vb <= 1'b1;
            end
        end
    end

    // clr discards this cycle's compare, so it takes priority over a miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err       <= 1'b0;
            bus.check_cnt <= '0;
            bus.err_cnt   <= '0;
            bus.first_z   <= '0;
            bus.first_exp <= '0;
        end else if (bus.clr) begin
            bus.err       <= 1'b0;
            bus.check_cnt <= '0;
            bus.err_cnt   <= '0;
            bus.first_z   <= '0;
            bus.first_exp <= '0;
        end else if (cmp) begin
            if (bus.check_cnt != '1)
                bus.check_cnt <= bus.check_cnt + 1'b1;
            if (miss) begin
                bus.err <= 1'b1;
                if (bus.err_cnt != '1)
                    bus.err_cnt <= bus.err_cnt + 1'b1;
                if (!bus.err) begin
                    bus.first_z   <= bus.z;
                    bus.first_exp <= exp_z;
                end
            end
        end
    end
endmodule

// File: doc/mul9x9_ireg_checker.md
# mul9x9_ireg_checker

Self-checking consumer for the 9x9 multiplier hardware test with registered A/B inputs and bypassed output. It observes the same strobe-qualified stimulus driven into the multiplier, keeps a cycle-accurate model of the multiplier's input registers, and compares the multiplier's combinational Z against the model's expected product every clock. It reports a sticky error, saturating check and error counts, and a snapshot of the first mismatch for readout by the test harness.

## Interface
- CNT_W, 16, width of the check and error counters (saturating).
- clk  input  1  single clock, shared with the multiplier under test.
- rst  input  1  asynchronous, active-high reset of all checker state.
- clr  input  1  synchronous clear of counters, error flag and snapshot; does not touch the model registers.
- strobe  input  1  stimulus qualifier, identical to the one gating the multiplier.
- cea, ceb  input  1 each  clock enables for A and B, effective only when strobe=1.
- rsta, rstb  input  1 each  synchronous resets for A and B, effective only when strobe=1.
- a_signed, b_signed  input  1 each  operand signedness, as driven to the multiplier.
- a, b  input  9 each  operands, as driven to the multiplier.
- z  input  18  multiplier product output under test.
- err  output  1  sticky mismatch flag.
- check_cnt  output  CNT_W  number of compared cycles.
- err_cnt  output  CNT_W  number of mismatching cycles.
- first_z, first_exp  output  18 each  observed and expected Z of the first mismatch.

## Operation
- Model registers ra, rb (9 bits) and valid flags va, vb.
- Each clk edge, per operand X in {a,b}: if strobe && rstX then rX<=0, vX<=1; else if strobe && ceX then rX<=X, vX<=1; else hold. Reset has priority over enable. With strobe=0, rstX and ceX are ignored.
- Expected product: extend ra to 18 bits (sign-extend if a_signed, else zero-extend), same for rb with b_signed; multiply; keep low 18 bits. Signedness is applied combinationally to the current register contents (not registered).
- Compare enable: cmp = va && vb. Register contents are undefined after power-up (global reset disabled), so no compare occurs until both operands have been loaded or reset at least once after rst.
- Each clk edge with cmp=1: check_cnt increments; if z != expected then err_cnt increments, err<=1, and if err was 0 the snapshot first_z/first_exp is captured. Counters saturate at all-ones and never wrap.
- clr=1: check_cnt, err_cnt, err, first_z, first_exp <= 0; compares in that cycle are discarded. va/vb/ra/rb still update normally.
- rst: all outputs 0, ra=rb=0, va=vb=0.

## Timing
- All outputs registered; reset value 0 for every output.
- Z is sampled at the same edge that may update ra/rb; comparison uses pre-edge ra/rb and current signedness, matching the multiplier's combinational Z in that cycle.
- Operand loaded at edge N is first compared at edge N+1; its result is visible on err/err_cnt after edge N+1.
- rst asserted mid-test: immediate clear; compares resume only after both operands are re-established.
- clr and a mismatch in the same cycle: clr wins.

## Test plan
- rst, then strobe=1 cea=ceb=1 a=9'h003 b=9'h005 unsigned, next cycle z=18'h0000F -> check_cnt=1, err=0.
- a=b=9'h1FF both signed loaded, z=18'h00001 -> no error; then a_signed=0 with same registers, z must be 18'h3FE01, drive 18'h00001 -> err=1, err_cnt=1, first_z=18'h00001, first_exp=18'h3FE01.
- After rst only cea pulsed (ceb never), z arbitrary for 10 cycles -> check_cnt=0, err=0; then rstb with strobe=1 -> checks begin, expected 0.
- Registers loaded a=9'h010 b=9'h010; then cea=1 a=9'h0FF with strobe=0 for 3 cycles -> ra holds, z=18'h00100 accepted, no error.
- rsta and cea both high with strobe=1, a=9'h055 -> ra=0, expected 0; drive z=0 -> no error.
- Force 2^CNT_W+3 checks with constant mismatch -> err_cnt and check_cnt stick at all-ones; first_* unchanged after first capture; clr -> all zero next cycle.
